// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the commit trace capture block: flag positions,
// record layout and the controller state encoding.
package cpu_trace_pkg;

  // Bit positions inside the 2-bit flags field {memwrite, regwrite}.
  localparam int FLAG_REGWRITE = 0;
  localparam int FLAG_MEMWRITE = 1;

  localparam int FLAGS_W = 2;
  localparam int DATA_W  = 32;

  // Record layout, MSB to LSB: {stamp, flags, regdata, memdata}.
  localparam int MEMDATA_LSB = 0;
  localparam int REGDATA_LSB = DATA_W;
  localparam int FLAGS_LSB   = 2 * DATA_W;
  localparam int STAMP_LSB   = FLAGS_LSB + FLAGS_W;

  // Width of everything except the stamp.
  localparam int REC_FIXED_W = FLAGS_W + 2 * DATA_W;

  // Full record width for a given stamp width.
  function automatic int rec_width(input int stamp_w);
    return REC_FIXED_W + stamp_w;
  endfunction

  // IDLE: FIFO empty. ACTIVE: at least one record held, head is valid.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/trace_fifo_mem.sv
// Record storage: DEPTH x WIDTH register array, one write port and one
// registered read port. A read of the address being written in the same
// cycle returns the new data, so an empty FIFO can present a fresh record
// one edge after it is written.
module trace_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 82,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  // NOTE: the array has no reset; occupancy lives in the controller, so
  // stale entries are never observed and the storage can map to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port with write-through on an address match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/wb_trace_fifo.sv
// Commit trace capture: records every cycle with a WB register write or a
// MEM store as a timestamped record, drains through a valid/ready port and
// keeps saturating commit/drop counters plus a sticky overflow flag.
module wb_trace_fifo
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       wb_regwrite,
  input  logic [31:0]                wb_regdata,
  input  logic                       mem_memwrite,
  input  logic [31:0]                mem_memdata,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [STAMP_W-1:0]         rd_stamp,
  output logic [1:0]                 rd_flags,
  output logic [31:0]                rd_regdata,
  output logic [31:0]                rd_memdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           commit_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int REC_W = rec_width(STAMP_W);

  ctrl_state_e        state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [STAMP_W-1:0] stamp_q;

  logic               event_hit, pop, full, push, drop;
  logic [1:0]         flags;
  logic [REC_W-1:0]   wr_rec, head_rec;

  // Free-running cycle stamp; only the async reset touches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stamp_q <= '0;
    else        stamp_q <= stamp_q + 1'b1;
  end

  // Event qualification and incoming record assembly.
  always_comb begin
    flags                = '0;
    flags[FLAG_REGWRITE] = wb_regwrite;
    flags[FLAG_MEMWRITE] = mem_memwrite;
    event_hit = en & (wb_regwrite | mem_memwrite);
    pop       = (state_q == ST_ACTIVE) & rd_ready;
    full      = (level_q == LVL_W'(DEPTH));
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    push      = event_hit & (~full | pop) & ~clr;
    drop      = event_hit & full & ~pop & ~clr;
    wr_rec    = {stamp_q, flags,
                 wb_regwrite  ? wb_regdata  : 32'h0,
                 mem_memwrite ? mem_memdata : 32'h0};
  end

  // Next-state: occupancy, pointers and IDLE/ACTIVE control.
  // NOTE: every signal assigned here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    level_d  = level_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    state_d  = state_q;
    if (clr) begin
      level_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      state_d  = ST_IDLE;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      case (state_q)
        ST_IDLE:   if (push) state_d = ST_ACTIVE;
        ST_ACTIVE: if (pop && !push && (level_q == LVL_W'(1))) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Controller state register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      level_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Saturating commit/drop counters and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else if (clr) begin
      commit_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push && (commit_cnt != '1)) commit_cnt <= commit_cnt + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  // Storage reads the next head address so the head register is always current.
  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_rec),
    .raddr (rd_ptr_d),
    .rdata (head_rec)
  );

  // Output unpacking; fields read as zero whenever no record is held.
  always_comb begin
    rd_valid   = (state_q == ST_ACTIVE);
    level      = level_q;
    rd_stamp   = '0;
    rd_flags   = '0;
    rd_regdata = '0;
    rd_memdata = '0;
    if (rd_valid) begin
      rd_stamp   = head_rec[STAMP_LSB   +: STAMP_W];
      rd_flags   = head_rec[FLAGS_LSB   +: FLAGS_W];
      rd_regdata = head_rec[REGDATA_LSB +: DATA_W];
      rd_memdata = head_rec[MEMDATA_LSB +: DATA_W];
    end
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Scoreboard bench for wb_trace_fifo: the driver models each cycle with a
// queue of expected records and plain counters; a monitor checks status
// every cycle and compares every record as it is handed over.
module tb_wb_trace_fifo;

  localparam int DEPTH   = 16;
  localparam int STAMP_W = 8;
  localparam int CNT_W   = 5;
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [STAMP_W-1:0] stamp;
    logic [1:0]         flags;
    logic [31:0]        regdata;
    logic [31:0]        memdata;
  } rec_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0, clr = 1'b0;
  logic               wb_regwrite = 1'b0, mem_memwrite = 1'b0;
  logic [31:0]        wb_regdata = '0, mem_memdata = '0;
  logic               rd_ready = 1'b0;
  logic               rd_valid;
  logic [STAMP_W-1:0] rd_stamp;
  logic [1:0]         rd_flags;
  logic [31:0]        rd_regdata, rd_memdata;
  logic [LVL_W-1:0]   level;
  logic               overflow;
  logic [CNT_W-1:0]   commit_cnt, drop_cnt;

  wb_trace_fifo #(.DEPTH(DEPTH), .STAMP_W(STAMP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .wb_regwrite(wb_regwrite), .wb_regdata(wb_regdata),
    .mem_memwrite(mem_memwrite), .mem_memdata(mem_memdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_stamp(rd_stamp),
    .rd_flags(rd_flags), .rd_regdata(rd_regdata), .rd_memdata(rd_memdata),
    .level(level), .overflow(overflow), .commit_cnt(commit_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state.
  rec_t               exp_q[$];
  int                 m_commit = 0, m_drop = 0;
  bit                 m_ovf = 1'b0;
  logic [STAMP_W-1:0] m_stamp;
  // Status the DUT should show between the current pair of edges.
  int                 exp_level = 0, exp_commit = 0, exp_drop = 0;
  bit                 exp_ovf = 1'b0;
  bit                 mon_en = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // The stamp is simply the number of clock edges since reset, modulo 2^STAMP_W.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_stamp <= '0;
    else        m_stamp <= m_stamp + 1'b1;
  end

  // One cycle of stimulus: drive inputs just after an edge and predict the
  // effect of the following edge.
  task automatic step(input bit e, input bit rw, input bit mw,
                      input logic [31:0] rdat, input logic [31:0] mdat,
                      input bit rdy, input bit cl);
    bit pop, ev;
    rec_t r;
    @(posedge clk);
    #1;
    exp_level  = exp_q.size();
    exp_commit = m_commit;
    exp_drop   = m_drop;
    exp_ovf    = m_ovf;
    en = e; wb_regwrite = rw; mem_memwrite = mw;
    wb_regdata = rdat; mem_memdata = mdat;
    clr = cl;
    rd_ready = cl ? 1'b0 : rdy;
    pop = (exp_q.size() > 0) && rd_ready;
    ev  = e && (rw || mw);
    if (cl) begin
      exp_q.delete();
      m_commit = 0; m_drop = 0; m_ovf = 1'b0;
    end else if (ev) begin
      if (exp_q.size() < DEPTH || pop) begin
        r.stamp   = m_stamp;
        r.flags   = {mw, rw};
        r.regdata = rw ? rdat : 32'h0;
        r.memdata = mw ? mdat : 32'h0;
        exp_q.push_back(r);
        if (m_commit < CNT_MAX) m_commit++;
      end else begin
        if (m_drop < CNT_MAX) m_drop++;
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rdy, 1'b0);
  endtask

  // Drain with a bounded cycle budget.
  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 4 * DEPTH) begin
      idle(1'b1);
      n++;
    end
    idle(1'b0);
    check("drain_complete", 128'(exp_q.size()), 128'(0));
  endtask

  // Monitor: status every cycle, record contents on every handshake.
  rec_t got;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("rd_valid", 128'(rd_valid), 128'(exp_level != 0));
      check("level", 128'(level), 128'(exp_level));
      check("commit_cnt", 128'(commit_cnt), 128'(exp_commit));
      check("drop_cnt", 128'(drop_cnt), 128'(exp_drop));
      check("overflow", 128'(overflow), 128'(exp_ovf));
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", 128'(1), 128'(0));
        end else begin
          got = exp_q.pop_front();
          check("rd_stamp", 128'(rd_stamp), 128'(got.stamp));
          check("rd_flags", 128'(rd_flags), 128'(got.flags));
          check("rd_regdata", 128'(rd_regdata), 128'(got.regdata));
          check("rd_memdata", 128'(rd_memdata), 128'(got.memdata));
        end
      end else if (!rd_valid) begin
        check("empty_fields_zero", {46'h0, rd_stamp, rd_flags, rd_regdata, rd_memdata}, 128'(0));
      end
    end
  end

  initial begin
    // Reset state, sampled while reset is held.
    #3;
    check("reset_rd_valid", 128'(rd_valid), 128'(0));
    check("reset_level", 128'(level), 128'(0));
    check("reset_counters", {overflow, commit_cnt, drop_cnt}, 128'(0));
    check("reset_fields", {rd_stamp, rd_flags, rd_regdata, rd_memdata}, 128'(0));
    #19 rst_n = 1'b1;
    mon_en = 1'b1;

    // Single register-write commit, then pop it.
    step(1, 1, 0, 32'h0000_002A, 32'h0, 0, 0);
    idle(0);
    idle(1);
    idle(0);

    // Simultaneous regwrite and store: one record, both flags.
    step(1, 1, 1, 32'h11, 32'h22, 0, 0);
    idle(0);
    drain();

    // Store only.
    step(1, 0, 1, 32'hDEAD_BEEF, 32'h3333, 0, 0);
    drain();

    // Overflow: 18 regwrites with no consumer.
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 18; i++) step(1, 1, 0, 32'h100 + i, 32'h0, 0, 0);
    idle(0);
    drain();

    // Full with a simultaneous pop: accepted, no drop.
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 1, 0, $urandom(), 32'h0, 0, 0);
    step(1, 0, 1, 32'h0, 32'h5555, 1, 0);
    idle(0);
    drain();

    // Capture disabled, then clear with a simultaneous event.
    for (int i = 0; i < 5; i++) step(0, 1, 0, $urandom(), 32'h0, 0, 0);
    idle(0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, $urandom(), 32'h0, 0, 0);
    step(1, 1, 1, 32'h77, 32'h88, 0, 1);
    idle(0);
    idle(0);

    // Commit counter saturation: 40 commits while streaming out.
    for (int i = 0; i < 40; i++) step(1, 1, 0, $urandom(), 32'h0, 1, 0);
    drain();

    // Randomized traffic; long enough for the stamp to wrap.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           $urandom(), $urandom(), $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
    end
    drain();

    // Asynchronous reset with four records queued, applied between edges.
    for (int i = 0; i < 4; i++) step(1, 1, 0, $urandom(), 32'h0, 0, 0);
    @(posedge clk);
    #1;
    en = 0; wb_regwrite = 0; mem_memwrite = 0; rd_ready = 0; clr = 0;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_rd_valid", 128'(rd_valid), 128'(0));
    check("async_rst_level", 128'(level), 128'(0));
    check("async_rst_counters", {overflow, commit_cnt, drop_cnt}, 128'(0));
    exp_q.delete();
    m_commit = 0; m_drop = 0; m_ovf = 1'b0;
    #4 rst_n = 1'b1;

    // Traffic after release.
    for (int i = 0; i < 30; i++) begin
      step(1, $urandom_range(0, 1) == 1, 1, $urandom(), $urandom(), $urandom_range(0, 1) == 1, 0);
    end
    drain();

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
